// File: rtl/user_nmi_bridge_pkg.sv
// user_nmi_bridge_pkg
// Shared types and constants for the user-core to SoC nmi bridge.
//   state_t            : bridge FSM state (2-bit).
//   nmi_req_t          : request fields captured when the core issues an access.
//   DEFAULT_ERR_RDATA  : read data returned on any error termination.
//   in_window()        : unsigned address-window membership test.
package user_nmi_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2,
        ERR  = 2'd3
    } state_t;

    localparam logic [31:0] DEFAULT_ERR_RDATA = 32'hDEAD_BEEF;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } nmi_req_t;

    // Offset arithmetic wraps modulo 2^32, so a window may straddle the top
    // of the address space and a size of 32'hFFFF_FFFF covers all but one byte.
    function automatic logic in_window(input logic [31:0] addr,
                                       input logic [31:0] base,
                                       input logic [31:0] size);
        logic [31:0] offset;
        offset = addr - base;
        return (offset < size);
    endfunction

endpackage

// File: rtl/nmi_if.sv
// nmi_if
// Native memory interface bundle.
//   master : drives valid, addr, wdata, wstrb; receives ready, rdata.
//   slave  : receives valid, addr, wdata, wstrb; drives ready, rdata.
// An access with wstrb == 0 is a read; any non-zero wstrb is a write.
interface nmi_if;
    logic        valid;
    logic        ready;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdata;

    modport master (
        output valid, addr, wdata, wstrb,
        input  ready, rdata
    );

    modport slave (
        input  valid, addr, wdata, wstrb,
        output ready, rdata
    );
endinterface

// File: rtl/user_nmi_bridge.sv
// user_nmi_bridge
// Registered bridge from the user core's nmi master to the SoC nmi fabric.
// Every output is taken straight from a flop (or a decode of the state
// register), so no combinational path runs from one side to the other.
// Accesses outside the permitted window are answered locally with an error;
// accesses that the SoC never acknowledges are terminated after
// TIMEOUT_CYCLES cycles with an error.
//   clk_i      : clock
//   rst_n_i    : asynchronous active-low reset
//   core_nmi   : slave port facing the user core
//   soc_nmi    : master port facing the SoC fabric
//   err_clr_i  : synchronous clear of the error status
//   err_irq_o  : one-cycle pulse per error termination
//   err_flag_o : sticky error flag
//   err_addr_o : word address of the most recent erroring access
//   err_cnt_o  : saturating error count
module user_nmi_bridge
    import user_nmi_bridge_pkg::*;
#(
    parameter logic [31:0] ALLOW_BASE     = 32'h0000_0000,
    parameter logic [31:0] ALLOW_SIZE     = 32'hFFFF_FFFF,
    parameter int          TIMEOUT_CYCLES = 256,
    parameter logic [31:0] ERR_RDATA      = DEFAULT_ERR_RDATA
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    nmi_if.slave        core_nmi,
    nmi_if.master       soc_nmi,
    input  logic        err_clr_i,
    output logic        err_irq_o,
    output logic        err_flag_o,
    output logic [31:0] err_addr_o,
    output logic [7:0]  err_cnt_o
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t          state_reg, state_next;
    nmi_req_t        req_reg, req_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [31:0]     rdata_reg, rdata_next;
    logic            err_flag_reg, err_flag_next;
    logic [31:0]     err_addr_reg, err_addr_next;
    logic [7:0]      err_cnt_reg, err_cnt_next;

    logic [31:0]     core_addr_aligned;

    // Masking rather than slicing keeps every core address bit referenced.
    assign core_addr_aligned = core_nmi.addr & 32'hFFFF_FFFC;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_reg    <= IDLE;
            req_reg      <= '0;
            cnt_reg      <= '0;
            rdata_reg    <= '0;
            err_flag_reg <= 1'b0;
            err_addr_reg <= '0;
            err_cnt_reg  <= '0;
        end else begin
            state_reg    <= state_next;
            req_reg      <= req_next;
            cnt_reg      <= cnt_next;
            rdata_reg    <= rdata_next;
            err_flag_reg <= err_flag_next;
            err_addr_reg <= err_addr_next;
            err_cnt_reg  <= err_cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        req_next   = req_reg;
        cnt_next   = cnt_reg;
        rdata_next = rdata_reg;

        case (state_reg)
            IDLE: begin
                if (core_nmi.valid) begin
                    req_next.addr  = core_addr_aligned;
                    req_next.wdata = core_nmi.wdata;
                    req_next.wstrb = core_nmi.wstrb;
                    cnt_next       = '0;
                    if (in_window(core_addr_aligned, ALLOW_BASE, ALLOW_SIZE)) begin
                        state_next = REQ;
                    end else begin
                        state_next = ERR;
                        rdata_next = ERR_RDATA;
                    end
                end
            end
            REQ: begin
                // A response arriving on the last allowed cycle beats the timeout.
                if (soc_nmi.ready) begin
                    rdata_next = (req_reg.wstrb == 4'b0000) ? soc_nmi.rdata : 32'h0;
                    state_next = RESP;
                end else if (cnt_reg == CNT_LAST) begin
                    rdata_next = ERR_RDATA;
                    state_next = ERR;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            RESP:    state_next = IDLE;
            ERR:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Error status: a new error outranks a coincident clear, and in that
    // case the count restarts at one instead of continuing.
    always_comb begin
        err_flag_next = err_flag_reg;
        err_addr_next = err_addr_reg;
        err_cnt_next  = err_cnt_reg;

        if (state_reg == ERR) begin
            err_flag_next = 1'b1;
            err_addr_next = req_reg.addr;
            if (err_clr_i) begin
                err_cnt_next = 8'd1;
            end else if (err_cnt_reg != 8'hFF) begin
                err_cnt_next = err_cnt_reg + 8'd1;
            end
        end else if (err_clr_i) begin
            err_flag_next = 1'b0;
            err_addr_next = '0;
            err_cnt_next  = '0;
        end
    end

    assign soc_nmi.valid  = (state_reg == REQ);
    assign soc_nmi.addr   = req_reg.addr;
    assign soc_nmi.wdata  = req_reg.wdata;
    assign soc_nmi.wstrb  = req_reg.wstrb;

    assign core_nmi.ready = (state_reg == RESP) || (state_reg == ERR);
    assign core_nmi.rdata = rdata_reg;

    assign err_irq_o  = (state_reg == ERR);
    assign err_flag_o = err_flag_reg;
    assign err_addr_o = err_addr_reg;
    assign err_cnt_o  = err_cnt_reg;

endmodule

// File: tb/tb_user_nmi_bridge.sv
// tb_user_nmi_bridge
// Randomised and directed transactions against a transaction-level model of
// the bridge: expected latency, SoC request count, read data and error
// status are derived from the window, timeout and status rules directly.
module tb_user_nmi_bridge;

    localparam logic [31:0] BASE = 32'h0000_0000;
    localparam logic [31:0] SIZE = 32'h0001_0000;
    localparam int          TO   = 8;
    localparam logic [31:0] ERRD = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        err_clr = 1'b0;
    logic        err_irq;
    logic        err_flag;
    logic [31:0] err_addr;
    logic [7:0]  err_cnt;

    nmi_if core_bus();
    nmi_if soc_bus();

    user_nmi_bridge #(
        .ALLOW_BASE     (BASE),
        .ALLOW_SIZE     (SIZE),
        .TIMEOUT_CYCLES (TO),
        .ERR_RDATA      (ERRD)
    ) dut (
        .clk_i      (clk),
        .rst_n_i    (rst_n),
        .core_nmi   (core_bus.slave),
        .soc_nmi    (soc_bus.master),
        .err_clr_i  (err_clr),
        .err_irq_o  (err_irq),
        .err_flag_o (err_flag),
        .err_addr_o (err_addr),
        .err_cnt_o  (err_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Model of the error status
    logic        m_flag = 1'b0;
    logic [7:0]  m_cnt  = 8'd0;
    logic [31:0] m_addr = 32'd0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic check_status(input string tag);
        check({tag, ".flag"}, {31'd0, err_flag}, {31'd0, m_flag});
        check({tag, ".cnt"},  {24'd0, err_cnt},  {24'd0, m_cnt});
        check({tag, ".addr"}, err_addr, m_addr);
    endtask

    // One complete core transaction. delay = number of SoC valid cycles
    // without ready before ready is given (>= TO means never in time).
    task automatic run_txn(input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] wstrb, input int delay,
                           input logic [31:0] srdata, input bit clr_at_err,
                           input bit verbose);
        logic [31:0] aligned, got_rdata, exp_rdata;
        int          exp_lat, exp_vcnt, lat, vcnt;
        bit          expect_err, done, fields_ok, irq_at, irq_early;

        aligned = addr & 32'hFFFF_FFFC;
        if ((aligned - BASE) >= SIZE) begin
            expect_err = 1; exp_lat = 1; exp_vcnt = 0; exp_rdata = ERRD;
        end else if (delay < TO) begin
            expect_err = 0; exp_lat = delay + 2; exp_vcnt = delay + 1;
            exp_rdata = (wstrb == 4'b0000) ? srdata : 32'h0;
        end else begin
            expect_err = 1; exp_lat = TO + 1; exp_vcnt = TO; exp_rdata = ERRD;
        end

        @(negedge clk);
        err_clr        = 1'b0;
        core_bus.valid = 1'b1;
        core_bus.addr  = addr;
        core_bus.wdata = wdata;
        core_bus.wstrb = wstrb;
        soc_bus.ready  = 1'b0;

        vcnt = 0; lat = 0; done = 0; fields_ok = 1; irq_at = 0; irq_early = 0;
        got_rdata = 32'h0;
        for (int k = 1; k <= 40 && !done; k++) begin
            @(negedge clk);
            if (soc_bus.valid) begin
                vcnt++;
                if (soc_bus.addr !== aligned || soc_bus.wdata !== wdata || soc_bus.wstrb !== wstrb)
                    fields_ok = 0;
            end
            soc_bus.ready = soc_bus.valid && (vcnt == delay + 1);
            soc_bus.rdata = soc_bus.ready ? srdata : $urandom;
            if (core_bus.ready) begin
                done      = 1;
                lat       = k;
                got_rdata = core_bus.rdata;
                irq_at    = err_irq;
                core_bus.valid = 1'b0;
                if (clr_at_err) err_clr = 1'b1;
            end else if (err_irq) begin
                irq_early = 1;
            end
        end
        soc_bus.ready = 1'b0;

        check("latency",   32'(lat),  32'(exp_lat));
        check("soc_valid_cycles", 32'(vcnt), 32'(exp_vcnt));
        check("rdata",     got_rdata, exp_rdata);
        check("irq",       {31'd0, irq_at}, {31'd0, expect_err});
        check("irq_early", {31'd0, irq_early}, 32'd0);
        check("soc_fields", {31'd0, fields_ok}, 32'd1);

        if (expect_err) begin
            m_flag = 1'b1;
            m_addr = aligned;
            if (clr_at_err)          m_cnt = 8'd1;
            else if (m_cnt < 8'd255) m_cnt = m_cnt + 8'd1;
        end

        @(negedge clk);
        err_clr = 1'b0;
        check_status("status");
        if (verbose)
            $display("txn addr=%h wstrb=%b delay=%0d lat=%0d rdata=%h err=%0d cnt=%0d",
                     addr, wstrb, delay, lat, got_rdata, expect_err, err_cnt);
    endtask

    initial begin
        logic [31:0] a;
        logic [3:0]  s;

        core_bus.valid = 1'b0;
        core_bus.addr  = 32'h0;
        core_bus.wdata = 32'h0;
        core_bus.wstrb = 4'h0;
        soc_bus.ready  = 1'b0;
        soc_bus.rdata  = 32'h0;

        #1;
        check("rst.core_ready", {31'd0, core_bus.ready}, 32'd0);
        check("rst.core_rdata", core_bus.rdata, 32'd0);
        check("rst.soc_valid",  {31'd0, soc_bus.valid}, 32'd0);
        check("rst.soc_addr",   soc_bus.addr, 32'd0);
        check("rst.soc_wdata",  soc_bus.wdata, 32'd0);
        check("rst.soc_wstrb",  {28'd0, soc_bus.wstrb}, 32'd0);
        check("rst.irq",        {31'd0, err_irq}, 32'd0);
        check_status("rst");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed cases
        run_txn(32'h0000_1004, 32'h0,         4'b0000, 0,  32'h1234_5678, 0, 1);
        run_txn(32'h0000_0203, 32'hA5A5_A5A5, 4'b0011, 0,  32'h7777_7777, 0, 1);
        run_txn(32'h0001_0000, 32'h0,         4'b0000, 0,  32'h0,         0, 1);
        run_txn(32'h0000_0040, 32'h0,         4'b0000, 20, 32'h5555_AAAA, 0, 1);
        run_txn(32'h0000_0044, 32'h0,         4'b0000, TO - 1, 32'hCAFE_F00D, 0, 1);
        run_txn(32'h0000_FFFF, 32'h0,         4'b0000, 1,  32'h0BAD_F00D, 0, 1);
        run_txn(32'hFFFF_FFFF, 32'h0,         4'b0000, 0,  32'h0,         0, 1);

        // Random mix of reads/writes, window hits/misses and SoC delays
        for (int i = 0; i < 60; i++) begin
            a = ($urandom_range(0, 3) == 3) ? (32'h0001_0000 + ($urandom & 32'h0FFF_FFFF))
                                            : ($urandom & 32'h0000_FFFF);
            s = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'b0000;
            run_txn(a, $urandom, s, $urandom_range(0, 10), $urandom, 0, 1);
        end

        // Saturation of the error counter
        for (int i = 0; i < 300; i++) begin
            run_txn(32'h0002_0000 + 32'(i * 4), 32'h0, 4'b0000, 0, 32'h0, 0, 0);
        end
        check("sat.cnt", {24'd0, err_cnt}, 32'h0000_00FF);
        $display("saturation run done cnt=%0d", err_cnt);

        // Clear coincident with an error cycle: the new error wins
        run_txn(32'h0003_0010, 32'h0, 4'b0000, 0, 32'h0, 1, 1);

        // Plain clear while idle
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        m_flag = 1'b0; m_cnt = 8'd0; m_addr = 32'd0;
        check_status("clear");
        $display("clear pulse flag=%0d cnt=%0d", err_flag, err_cnt);

        // Leave nonzero status so the reset check has something to wipe
        run_txn(32'h0004_0000, 32'h0, 4'b0000, 0, 32'h0, 0, 1);

        // Asynchronous reset during REQ
        @(negedge clk);
        core_bus.valid = 1'b1;
        core_bus.addr  = 32'h0000_0100;
        core_bus.wdata = 32'h1111_2222;
        core_bus.wstrb = 4'b1111;
        soc_bus.ready  = 1'b0;
        repeat (3) @(negedge clk);
        check("arst.pre_valid", {31'd0, soc_bus.valid}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst.soc_valid",  {31'd0, soc_bus.valid}, 32'd0);
        check("arst.core_ready", {31'd0, core_bus.ready}, 32'd0);
        check("arst.soc_addr",   soc_bus.addr, 32'd0);
        check("arst.core_rdata", core_bus.rdata, 32'd0);
        m_flag = 1'b0; m_cnt = 8'd0; m_addr = 32'd0;
        check_status("arst");
        $display("async reset in REQ valid=%0d flag=%0d", soc_bus.valid, err_flag);
        core_bus.valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        run_txn(32'h0000_2008, 32'h0, 4'b0000, 2, 32'h89AB_CDEF, 0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/user_nmi_bridge.md
Name: user_nmi_bridge

Overview:
- Registered bridge between the user core's native memory master and the SoC-side nmi fabric.
- Instantiated directly downstream of the user core design.
- Cuts the combinational valid/ready/rdata path to improve timing.
- Rejects accesses outside a permitted address window.
- Terminates hung transactions with a bus-timeout error response.
- Exposes sticky error status and an error interrupt pulse.

Parameters:
- ALLOW_BASE, 32'h0000_0000, inclusive lower bound of permitted byte address window.
- ALLOW_SIZE, 32'hFFFF_FFFF, window size in bytes; address accepted iff (addr - ALLOW_BASE) < ALLOW_SIZE, computed unsigned 32-bit.
- TIMEOUT_CYCLES, 256, soc-side wait cycles before forced error; legal range 2..65535.
- ERR_RDATA, 32'hDEAD_BEEF, rdata returned on any error termination.

Ports:
- clk_i  input  1  clock.
- rst_n_i  input  1  reset; asynchronous, active-low.
- core_nmi  nmi_if.slave  -  from user core: valid, addr[31:0], wdata[31:0], wstrb[3:0] in; ready, rdata[31:0] out.
- soc_nmi  nmi_if.master  -  to SoC fabric: valid, addr, wdata, wstrb out; ready, rdata in.
- err_clr_i  input  1  synchronous clear of the error status.
- err_irq_o  output  1  one-cycle pulse per error termination.
- err_flag_o  output  1  sticky error flag.
- err_addr_o  output  32  address of the most recent erroring access.
- err_cnt_o  output  8  saturating error count.

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, timeout counter 0. core_nmi.rdata and soc_nmi.addr/wdata/wstrb are also 0.
- Reset asserted mid-transaction: soc_nmi.valid and core_nmi.ready drop immediately (asynchronous). The in-flight access is abandoned.
- FSM states: IDLE, REQ, RESP, ERR.
- IDLE:
  - On core_nmi.valid=1, latch {addr[31:2],2'b00}, wdata and wstrb.
  - In window -> REQ, counter cleared.
  - Out of window -> ERR; no soc request is ever issued.
- REQ:
  - soc_nmi.valid=1 with the latched fields held stable.
  - On soc_nmi.ready=1: register soc_nmi.rdata (reads only; a write returns 0) -> RESP.
  - Otherwise the counter increments. When the counter == TIMEOUT_CYCLES-1 and ready=0: -> ERR, and soc_nmi.valid drops the next cycle.
  - ready=1 in the same cycle the counter hits the limit: the response wins, go to RESP.
- RESP: core_nmi.ready=1 for exactly one cycle with the registered rdata -> IDLE.
- ERR:
  - core_nmi.ready=1 for one cycle with rdata=ERR_RDATA.
  - err_irq_o=1 that cycle.
  - err_flag_o set; err_addr_o loaded with the latched address.
  - err_cnt_o incremented, saturating at 8'hFF.
  - Then -> IDLE.
- Latency:
  - Minimum core valid -> core ready is 3 cycles (soc ready in the first REQ cycle).
  - Timeout path: TIMEOUT_CYCLES+2 cycles.
- Back-to-back: the bridge returns to IDLE for one cycle after each response, so a new request is accepted no earlier than the cycle after core ready.
- Core valid deasserted while in REQ (protocol violation): ignored; the transaction completes and the response is still issued.
- err_clr_i clears err_flag_o, err_cnt_o and err_addr_o.
- err_clr_i coincident with an ERR cycle: the new error wins. Result is flag=1, cnt=1, addr=new.
- A single outstanding transaction only; no pipelining.
- Byte lanes and wstrb pass through unmodified.

Decomposition:
- Package user_nmi_bridge_pkg holds:
  - state enum (IDLE, REQ, RESP, ERR), 2-bit;
  - default ERR_RDATA constant;
  - typedef of the latched request struct {addr, wdata, wstrb}.
- Timeout counter width is $clog2(TIMEOUT_CYCLES).
- No sub-module is needed; counter, window check and FSM live in one module.

Test Plan:
- Read at 32'h0000_1004 with ALLOW_BASE=0, ALLOW_SIZE=32'h1_0000; SoC returns ready in its first valid cycle with rdata 32'h1234_5678 -> core ready 3 cycles after valid with rdata 32'h1234_5678; err_flag_o stays 0.
- Write wdata 32'hA5A5_A5A5, wstrb 4'b0011 to 32'h0000_0203 -> soc addr 32'h0000_0200, wdata/wstrb unchanged; core rdata 0.
- Access to 32'h0001_0000 (just outside window) -> soc valid never asserts; core ready after 2 cycles with 32'hDEAD_BEEF; err_irq_o 1-cycle pulse; err_addr_o 32'h0001_0000; err_cnt_o 1.
- TIMEOUT_CYCLES=8, SoC never ready -> soc valid high exactly 8 cycles; core gets 32'hDEAD_BEEF at cycle 10. Repeat with ready in the 8th cycle -> normal response, no error.
- 300 consecutive window violations -> err_cnt_o saturates at 8'hFF. err_clr_i during a further error cycle -> cnt=1, flag=1.
- rst_n_i asserted during REQ -> soc valid drops with no clock edge, all status 0; next access after reset completes normally.
